// File: rtl/aes_key_schedule_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule_pkg
// Description : Shared FSM encoding, AES-128 constants, S-box table and xtime
// Revision    : 1.0 - initial release
// ============================================================================
package aes_key_schedule_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_MIX  = 2'd2
  } state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RED_POLY  = 8'h1B;
  localparam logic [3:0] NROUNDS   = 4'd10;

  // Forward AES S-box; element 0 is the most significant byte of the literal
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8), used to step the round constant
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_schedule_s4.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule_s4
// Description : Registered 4-byte S-box substitution stage
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule_s4
  import aes_key_schedule_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  logic [31:0] r_word;

  // Substitute all four bytes and capture them when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= 32'h0;
    end else if (i_en) begin
      r_word <= {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                 SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};
    end
  end

  assign o_word = r_word;

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule
// Description : AES-128 round-key generator, one round key per two enabled
//               cycles (SUB: S-box of RotWord, MIX: XOR chain)
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule
  import aes_key_schedule_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_start,
  input  logic [127:0] i_key_in,
  output logic [127:0] o_key_out,
  output logic [3:0]   o_round_idx,
  output logic         o_key_valid,
  output logic         o_busy,
  output logic         o_done
);

  state_t       r_state;
  state_t       w_next_state;
  logic [127:0] r_key;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;
  logic         r_valid;
  logic         r_busy;
  logic         r_done;

  logic         w_sub_en;
  logic         w_accept;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_w0;
  logic [31:0]  w_w1;
  logic [31:0]  w_w2;
  logic [31:0]  w_w3;
  logic [3:0]   w_round_nxt;

  // A start seen while done is still presented belongs to the finishing
  // schedule and is dropped; the next enabled cycle may start again.
  assign w_accept    = i_en && (r_state == ST_IDLE) && i_start && !r_done;
  assign w_sub_en    = i_en && (r_state == ST_SUB);
  assign w_rot       = {r_key[23:0], r_key[31:24]};
  assign w_round_nxt = r_round + 4'd1;

  assign w_w0 = r_key[127:96] ^ w_sub ^ {r_rcon, 24'h0};
  assign w_w1 = r_key[95:64]  ^ w_w0;
  assign w_w2 = r_key[63:32]  ^ w_w1;
  assign w_w3 = r_key[31:0]   ^ w_w2;

  aes_key_schedule_s4 u_s4 (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_sub_en),
    .i_word (w_rot),
    .o_word (w_sub)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; nothing moves while en is low
  always_comb begin
    w_next_state = r_state;
    if (i_en) begin
      case (r_state)
        ST_IDLE: if (w_accept) w_next_state = ST_SUB;
        ST_SUB:  w_next_state = ST_MIX;
        ST_MIX:  w_next_state = (w_round_nxt == NROUNDS) ? ST_IDLE : ST_SUB;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Round key, index, round constant and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key   <= 128'h0;
      r_round <= 4'd0;
      r_rcon  <= RCON_INIT;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_en) begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_key   <= i_key_in;
            r_round <= 4'd0;
            r_rcon  <= RCON_INIT;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_SUB: begin
          r_valid <= 1'b0;
        end
        ST_MIX: begin
          r_key   <= {w_w0, w_w1, w_w2, w_w3};
          r_round <= w_round_nxt;
          r_rcon  <= xtime(r_rcon);
          r_valid <= 1'b1;
          r_done  <= (w_round_nxt == NROUNDS);
        end
        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_key_out   = r_key;
  assign o_round_idx = r_round;
  assign o_key_valid = r_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
`default_nettype wire
